// File: rtl/sistema_alarme_temperatura_param_if.sv
// Bus between the sensor sampling logic, the temperature alarm core and the
// control-room annunciator: samples, thresholds, acknowledge and alarm outputs.
interface sistema_alarme_temperatura_param_if #(
    parameter int unsigned N_CANAIS = 7,
    parameter int unsigned LARGURA  = 8,
    parameter int unsigned IDX_W    = 3
);
    logic                        amostraValida;
    logic [N_CANAIS*LARGURA-1:0] temperaturas;
    logic [N_CANAIS*LARGURA-1:0] limites;
    logic                        reconhece;
    logic                        alarmeSonoroTemperatura;
    logic [N_CANAIS-1:0]         alarmeCanal;
    logic [IDX_W-1:0]            primeiroCanal;
    logic                        primeiroValido;
    logic [7:0]                  contAlarmes;

    modport master (
        output amostraValida, temperaturas, limites, reconhece,
        input  alarmeSonoroTemperatura, alarmeCanal, primeiroCanal,
               primeiroValido, contAlarmes
    );

    modport slave (
        input  amostraValida, temperaturas, limites, reconhece,
        output alarmeSonoroTemperatura, alarmeCanal, primeiroCanal,
               primeiroValido, contAlarmes
    );
endinterface

// File: rtl/sistema_alarme_temperatura_param.sv
// Multi-channel temperature alarm: per-channel debounce, hysteresis, latched
// alarm with acknowledge, first-out capture and saturating event counter.
module sistema_alarme_temperatura_param #(
    parameter int unsigned N_CANAIS = 7,
    parameter int unsigned LARGURA  = 8,
    parameter int unsigned HIST     = 5,
    parameter int unsigned PERSIST  = 3,
    parameter int unsigned IDX_W    = 3
) (
    input logic                          clk,
    input logic                          rst_n,
    sistema_alarme_temperatura_param_if.slave bus
);
    localparam int unsigned CNT_W = (PERSIST > 1) ? $clog2(PERSIST) : 1;

    typedef enum logic [1:0] {
        NORMAL      = 2'b00,
        SUSPEITO    = 2'b01,
        ALARME      = 2'b10,
        RECONHECIDO = 2'b11
    } estado_t;

    logic [N_CANAIS-1:0] w_entra;
    logic [N_CANAIS-1:0] w_alarme;
    logic [N_CANAIS-1:0] w_reconh;
    logic [N_CANAIS-1:0] w_normal;
    logic [IDX_W-1:0]    w_idx_entra;
    logic                w_todos_normal;

    logic                r_prim_valido;
    logic [IDX_W-1:0]    r_prim_canal;
    logic [7:0]          r_cont;

    for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
        estado_t           r_estado;
        logic [CNT_W-1:0]  r_cnt;
        logic [LARGURA-1:0] w_temp;
        logic [LARGURA-1:0] w_lim;
        logic [LARGURA:0]   w_soma;
        logic               w_trip;
        logic               w_clear;
        logic               w_cnt_final;

        assign w_temp      = bus.temperaturas[g*LARGURA +: LARGURA];
        assign w_lim       = bus.limites[g*LARGURA +: LARGURA];
        // Clear threshold evaluated one bit wider so temp + HIST cannot wrap.
        assign w_soma      = {1'b0, w_temp} + (LARGURA+1)'(HIST);
        assign w_trip      = (w_temp >= w_lim);
        assign w_clear     = (w_soma < {1'b0, w_lim});
        assign w_cnt_final = ((32'(r_cnt) + 32'd1) == PERSIST);

        assign w_entra[g]  = bus.amostraValida && w_trip &&
                             (((r_estado == NORMAL) && (PERSIST == 1)) ||
                              ((r_estado == SUSPEITO) && w_cnt_final));
        assign w_alarme[g] = (r_estado == ALARME);
        assign w_reconh[g] = (r_estado == RECONHECIDO);
        assign w_normal[g] = (r_estado == NORMAL);

        // Channel FSM; sampling gaps freeze the debounce count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_estado <= NORMAL;
                r_cnt    <= '0;
            end else begin
                case (r_estado)
                    NORMAL: begin
                        if (bus.amostraValida && w_trip) begin
                            if (PERSIST == 1) begin
                                r_estado <= ALARME;
                                r_cnt    <= '0;
                            end else begin
                                r_estado <= SUSPEITO;
                                r_cnt    <= CNT_W'(1);
                            end
                        end
                    end
                    SUSPEITO: begin
                        if (bus.amostraValida) begin
                            if (!w_trip) begin
                                r_estado <= NORMAL;
                                r_cnt    <= '0;
                            end else if (w_cnt_final) begin
                                r_estado <= ALARME;
                                r_cnt    <= '0;
                            end else begin
                                r_cnt    <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ALARME: begin
                        if (bus.reconhece) begin
                            r_estado <= RECONHECIDO;
                        end
                    end
                    RECONHECIDO: begin
                        if (bus.amostraValida && w_clear) begin
                            r_estado <= NORMAL;
                        end
                    end
                    default: begin
                        r_estado <= NORMAL;
                        r_cnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign w_todos_normal = &w_normal;

    // Lowest channel entering alarm on this edge.
    always_comb begin
        w_idx_entra = '0;
        for (int i = int'(N_CANAIS) - 1; i >= 0; i--) begin
            if (w_entra[i]) begin
                w_idx_entra = IDX_W'(i);
            end
        end
    end

    // First-out capture and saturating alarm-event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prim_valido <= 1'b0;
            r_prim_canal  <= '0;
            r_cont        <= '0;
        end else begin
            if (r_prim_valido && !w_todos_normal) begin
                r_prim_valido <= 1'b1;
            end else if (|w_entra) begin
                r_prim_valido <= 1'b1;
                r_prim_canal  <= w_idx_entra;
            end else begin
                r_prim_valido <= 1'b0;
                r_prim_canal  <= '0;
            end
            if ((|w_entra) && (r_cont != 8'hFF)) begin
                r_cont <= r_cont + 8'd1;
            end
        end
    end

    assign bus.alarmeSonoroTemperatura = |w_alarme;
    assign bus.alarmeCanal             = w_alarme | w_reconh;
    assign bus.primeiroCanal           = r_prim_canal;
    assign bus.primeiroValido          = r_prim_valido;
    assign bus.contAlarmes             = r_cont;

endmodule

// File: doc/sistema_alarme_temperatura_param.md
Name: sistema_alarme_temperatura_param

Overview:
- Parametrised, clocked successor of the plant temperature alarm. Monitors N_CANAIS temperature sensors (control room, sectors, pipes, reactor), each against its own runtime threshold.
- Adds debounce (persistence), hysteresis, latched alarm with operator acknowledge, first-out channel capture and a saturating alarm-event counter.
- Sits between the sensor sampling logic and the control-room annunciator/siren.

Parameters:
- N_CANAIS, 7, number of monitored channels (1..16)
- LARGURA, 8, width of each temperature sample and threshold (unsigned)
- HIST, 5, hysteresis in LSBs below threshold required to clear
- PERSIST, 3, consecutive valid over-threshold samples required to alarm (>=1)
- IDX_W, 3, width of channel index output (>= clog2(N_CANAIS), min 1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- amostraValida  in  1  all channel samples valid this cycle
- temperaturas  in  N_CANAIS*LARGURA  packed samples, channel i at [i*LARGURA +: LARGURA]
- limites  in  N_CANAIS*LARGURA  packed per-channel trip thresholds, same packing
- reconhece  in  1  operator acknowledge (level, sampled each edge)
- alarmeSonoroTemperatura  out  1  siren: any channel in ALARME
- alarmeCanal  out  N_CANAIS  per-channel alarm indication (ALARME or RECONHECIDO)
- primeiroCanal  out  IDX_W  index of first channel to alarm
- primeiroValido  out  1  primeiroCanal holds a captured value
- contAlarmes  out  8  alarm-event counter, saturates at 255

Behaviour:
- Clock clk, reset rst_n: asynchronous, active-low. Reset takes effect immediately without a clock edge: all channel states NORMAL, persistence counters 0, all outputs 0. Reset mid-alarm discards latched alarms.
- All outputs are decoded from registers. No combinational path from inputs to outputs. A sample presented at edge k is reflected on the outputs right after edge k.
- Trip: temp >= limite (unsigned).
- Clear: temp + HIST < limite, computed in LARGURA+1 bits. If limite <= HIST the channel can never clear by temperature (documented, not an error).
- Per-channel FSM, 2-bit state plus persistence counter:
  - NORMAL: on amostraValida & trip, go to ALARME if PERSIST==1, else go to SUSPEITO with cnt=1.
  - SUSPEITO: on amostraValida & trip, cnt+1; when cnt+1==PERSIST go to ALARME with cnt=0. On amostraValida & !trip, go to NORMAL with cnt=0. If amostraValida=0, hold state and cnt (gaps do not reset debounce).
  - ALARME: latched. Temperature is ignored. On reconhece=1, go to RECONHECIDO. If reconhece and amostraValida coincide, the acknowledge wins and the sample is not evaluated for clear that cycle.
  - RECONHECIDO: on amostraValida & clear, go to NORMAL. Otherwise hold; re-trip does not re-sound.
- reconhece in NORMAL, SUSPEITO or RECONHECIDO has no effect.
- alarmeSonoroTemperatura = OR over channels of (state==ALARME).
- alarmeCanal[i] = state_i in {ALARME, RECONHECIDO}.
- First-out capture:
  - When primeiroValido=0 and one or more channels enter ALARME on the same edge, capture the lowest such index and set primeiroValido=1.
  - While primeiroValido=1, no recapture.
  - primeiroValido and primeiroCanal clear on the edge after all channel states are NORMAL.
- contAlarmes: +1 per edge at which at least one channel enters ALARME (not per channel). Holds at 255.

Test Plan:
- Setup for all scenarios: N_CANAIS=7, LARGURA=8, HIST=5, PERSIST=3; limites ch0=50, ch1..ch6=100.
- Debounce: ch3=100 for 2 valid samples, then 90 -> no alarm. Then ch3=100 on 3 valid samples, with amostraValida=0 idle cycles between them -> after 3rd valid edge: siren=1, alarmeCanal=0001000b, primeiroCanal=3, primeiroValido=1, contAlarmes=1.
- Latch and acknowledge: with ch3 in ALARME, ch3 drops to 20 without reconhece -> siren stays 1. Pulse reconhece together with a valid sample of 20 -> siren=0, alarmeCanal[3]=1 (ack wins). Next valid sample 20 -> alarmeCanal=0, primeiroValido=0 one edge later.
- Hysteresis: ch3 in RECONHECIDO, valid samples 96 then 95 -> stays (95+5 not < 100). Sample 94 -> NORMAL. Sample 100 after acknowledge while RECONHECIDO -> no re-sound.
- Simultaneous and boundary: ch0=50 and ch5=100 trip on the same edges -> primeiroCanal=0, contAlarmes increments by 1 only. Repeat with ch0=49 -> ch0 never trips.
- Async reset: assert rst_n=0 mid-cycle while siren=1 and contAlarmes=255 (driven to saturation, no further increment checked) -> all outputs 0 before the next clk edge. Release rst_n, apply one trip sample -> SUSPEITO only, no alarm.
